// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3) with valid/ready on both sides.
// Define BIN_TO_BCD_LZB_EN to blank leading zero digits (4'hF) in the presented result.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam int CNT_W = $clog2(BIN_W + 1);

    // True when 10^DIGITS > 2^BIN_W - 1, i.e. every input value fits in DIGITS digits.
    function automatic bit digits_ok();
        logic [BIN_W+4:0] p;
        logic [BIN_W+4:0] limit;
        limit = (BIN_W+5)'(1) << BIN_W;
        p     = (BIN_W+5)'(1);
        for (int i = 0; i < DIGITS; i++) begin
            if (p < limit) p = p * (BIN_W+5)'(10);
        end
        return p >= limit;
    endfunction

    if (BIN_W < 1) begin : g_bad_width
        $error("bin_to_bcd_seq: BIN_W must be at least 1");
    end
    if (!digits_ok()) begin : g_bad_digits
        $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
    end

    state_t               state;
    state_t               state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [BIN_W-1:0]     shreg;
    logic [4*DIGITS-1:0]  scratch;
    logic [4*DIGITS-1:0]  scratch_adj;
    logic [4*DIGITS-1:0]  bcd_done;
`ifdef BIN_TO_BCD_LZB_EN
    logic                 lead;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: each combinational block assigns a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)             state_nxt = SHIFT;
            SHIFT:   if (cnt == CNT_W'(1))     state_nxt = DONE;
            DONE:    if (out_ready)            state_nxt = IDLE;
            default:                           state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        bcd       = (state == DONE) ? bcd_done : '0;
    end

    // Per-digit add-3 correction applied before each shift; no carry crosses digits.
    always_comb begin
        scratch_adj = scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (scratch[4*d +: 4] >= 4'd5) scratch_adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
        end
    end

    always_comb begin
        bcd_done = scratch;
`ifdef BIN_TO_BCD_LZB_EN
        lead = 1'b1;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            if (lead && scratch[4*d +: 4] == 4'h0) bcd_done[4*d +: 4] = 4'hF;
            else                                   lead = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            scratch <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg   <= bin;
                        scratch <= '0;
                        cnt     <= CNT_W'(BIN_W);
                    end
                end
                SHIFT: begin
                    // Binary MSB moves into scratch bit 0.
                    {scratch, shreg} <= {scratch_adj[4*DIGITS-2:0], shreg, 1'b0};
                    cnt              <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm. It accepts an unsigned binary word through a valid/ready handshake and, after a fixed number of cycles, presents the packed BCD digits through a second valid/ready handshake. It sits directly upstream of the per-digit BCD-to-7-segment decoders: each 4-bit digit slice of `bcd` drives one decoder instance.

## Interface
- `BIN_W`, default 16: width of the binary input; must be ≥ 1.
- `DIGITS`, default 5: number of BCD output digits.
  - Elaboration fails with `$error` unless 10^DIGITS > 2^BIN_W − 1.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: `bin` is valid.
- `in_ready` output 1: block can accept a new word.
- `bin` input BIN_W: unsigned binary value.
- `out_valid` output 1: `bcd` holds a completed result.
- `out_ready` input 1: consumer accepts the result.
- `bcd` output 4*DIGITS: packed BCD; digit 0 (units) is in bits [3:0].

## Operation
- FSM states: IDLE, SHIFT, DONE.
  - In IDLE, `in_ready` = 1.
  - In SHIFT and DONE, `in_ready` = 0, and `in_valid` is ignored (no buffering, no error).
- IDLE → SHIFT when `in_valid` && `in_ready`:
  - Capture `bin` into the shift register.
  - Clear the BCD scratch register to 0.
  - Load the bit counter with BIN_W.
- Each SHIFT cycle:
  - Every scratch digit ≥ 5 gets +3 (4-bit add, no carry between digits).
  - The concatenation {scratch, shift register} then shifts left by 1, so the binary MSB enters scratch bit 0.
  - The counter decrements by 1.
- SHIFT → DONE on the cycle in which the counter reaches 0, i.e. after exactly BIN_W shift cycles.
- In DONE:
  - `out_valid` = 1.
  - `bcd` = scratch; it is stable and unchanged while `out_ready` = 0.
- DONE → IDLE when `out_ready` = 1. There is no direct DONE → SHIFT path.
- Outside DONE, `bcd` is driven to all zeros.
- Digits above the highest needed are 0; the value never exceeds 9 in any digit.

## Timing
- Reset values while `rst_n` = 0 and after release:
  - state = IDLE
  - `in_ready` = 1
  - `out_valid` = 0
  - `bcd` = 0
  - counter and registers = 0
- Latency: input handshake at rising edge E; `out_valid` rises after edge E+BIN_W, i.e. BIN_W cycles after acceptance.
- `in_ready` rises one cycle after the output handshake edge.
- Throughput: one conversion per BIN_W + 2 cycles with `out_ready` tied high.
- `out_ready` is sampled only in DONE; `out_ready` high in IDLE or SHIFT has no effect.
- `rst_n` asserted mid-SHIFT or in DONE aborts the conversion immediately (asynchronously), and the result is discarded.
- Outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.

## Configuration
- `BIN_TO_BCD_LZB_EN` (leading-zero blanking).
- Defined:
  - In DONE, each leading zero digit is replaced by 4'hF, starting from digit DIGITS−1 down to the first nonzero digit.
  - Digit 0 is never blanked.
  - The downstream decoder renders 4'hF as a dark digit.
- Undefined: `bcd` in DONE is the raw result, with leading zeros = 4'h0.
- The macro has no effect on timing, handshake, or the all-zero `bcd` value outside DONE.

## Test plan
- `bin`=0, macro off → `bcd`=20'h00000 with `out_valid` 16 cycles after acceptance; with macro on → 20'hFFFF0.
- `bin`=65535 → `bcd`=20'h65535; `bin`=1234 with macro on → 20'hF1234; `bin`=9 with macro on → 20'hFFFF9.
- Back-pressure: hold `out_ready`=0 for 10 cycles in DONE → `bcd` and `out_valid` stable, `in_ready`=0 throughout; on release, `in_ready`=1 on the next cycle.
- Pulse `in_valid` with `bin`=42 during SHIFT of `bin`=100 → result is 20'h00100, and 42 is never converted.
- Assert `rst_n`=0 at shift cycle 7 → `out_valid`=0, `bcd`=0, `in_ready`=1 immediately; a subsequent conversion of 500 yields 20'h00500.
- BIN_W=8, DIGITS=3, random sweep of all 256 inputs back-to-back with `out_ready`=1 → every result matches the reference model and one result arrives every 10 cycles.
